// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. It decodes the opcode
//   held in IR and sequences fetch / decode / execute / memory / writeback.
//   It produces the 2-bit ALUOp consumed by the ALU control decoder
//   (00 add, 01 sub, 10 decode funct). Memory accesses wait on mem_ready.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     opcode[5:0]       IR[31:26], stable from DECODE onward
//     mem_ready         memory completes the current access this cycle
//     PCWrite           unconditional PC load
//     PCWriteCond       PC load if ALU zero
//     IorD              memory address: 0=PC, 1=ALUOut
//     MemRead/MemWrite  memory read / write request
//     IRWrite           load IR from memory data
//     MemtoReg          regfile write data: 0=ALUOut, 1=MDR
//     RegDst            destination register: 0=rt, 1=rd
//     RegWrite          regfile write enable
//     ALUSrcA           0=PC, 1=reg A
//     ALUSrcB[1:0]      00=B, 01=4, 10=signext imm, 11=signext imm<<2
//     ALUOp[1:0]        00 add, 01 sub, 10 funct
//     PCSource[1:0]     00=ALU result, 01=ALUOut, 10=jump target
//     illegal_op        one-cycle pulse after an unknown opcode in DECODE
//     state[3:0]        current state code (debug)
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXE    = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BEQ      = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EXE = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;

  logic [3:0] r_state;
  logic       r_illegal;
  logic [3:0] w_next;
  logic       w_illegal;

  // Next-state decode.
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            w_next = S_R_EXE;
        else if (opcode == OP_BEQ)              w_next = S_BEQ;
        else if (opcode == OP_J)                w_next = S_JUMP;
        else if (opcode == OP_ADDI)             w_next = S_ADDI_EXE;
        else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXE:    w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_ADDI_EXE: w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
    end
  end

  // Moore output decode; only IRWrite/PCWrite in FETCH look at mem_ready.
  // rst overrides everything so an aborted instruction writes nothing.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = r_illegal;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      default: illegal_op = 1'b0;
    endcase
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each cycle's expected state and control
// vector is queued when inputs are driven and checked at the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [20:0] sb[$];

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Expected controls, packed as
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
  function automatic logic [16:0] ctrl_of(input logic [3:0] s, input logic mr,
                                          input logic ill);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, bad_st;
    logic [1:0] asb, aop, pcs;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00; bad_st = 1'b0;
    case (s)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
      4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: rw = 1'b1;
      default: bad_st = 1'b1;
    endcase
    if (bad_st) return '0;
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic cyc(input logic r, input logic mr, input logic [3:0] es,
                     input logic ill, input string tag);
    logic [20:0] e, a;
    rst       = r;
    mem_ready = mr;
    sb.push_back(r ? {es, 17'd0} : {es, ctrl_of(es, mr, ill)});
    @(negedge clk);
    a = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    e = sb.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got state=%0d ctrl=%05h, want state=%0d ctrl=%05h",
               tag, a[20:17], a[16:0], e[20:17], e[16:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 4'd0, 1'b0, "reset_1");
    cyc(1'b1, 1'b1, 4'd0, 1'b0, "reset_2");
  endtask

  task automatic test_rtype();
    opcode = 6'b000000;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "r_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "r_decode");
    cyc(1'b0, 1'b1, 4'd6, 1'b0, "r_exe");
    cyc(1'b0, 1'b1, 4'd7, 1'b0, "r_wb");
  endtask

  task automatic test_lw_wait();
    opcode = 6'b100011;
    cyc(1'b0, 1'b0, 4'd0, 1'b0, "lw_fetch_wait");
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "lw_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "lw_decode");
    cyc(1'b0, 1'b1, 4'd2, 1'b0, "lw_addr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd3, 1'b0, "lw_rd_wait");
    cyc(1'b0, 1'b1, 4'd3, 1'b0, "lw_rd");
    cyc(1'b0, 1'b1, 4'd4, 1'b0, "lw_wb");
  endtask

  task automatic test_sw();
    opcode = 6'b101011;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "sw_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "sw_decode");
    cyc(1'b0, 1'b1, 4'd2, 1'b0, "sw_addr");
    cyc(1'b0, 1'b1, 4'd5, 1'b0, "sw_wr");
  endtask

  task automatic test_back_to_back();
    opcode = 6'b000100;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "beq_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "beq_decode");
    cyc(1'b0, 1'b1, 4'd8, 1'b0, "beq_exe");
    opcode = 6'b000010;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "j_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "j_decode");
    cyc(1'b0, 1'b1, 4'd9, 1'b0, "j_exe");
    opcode = 6'b001000;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "addi_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "addi_decode");
    cyc(1'b0, 1'b1, 4'd10, 1'b0, "addi_exe");
    cyc(1'b0, 1'b1, 4'd11, 1'b0, "addi_wb");
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "ill_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "ill_decode");
    cyc(1'b0, 1'b0, 4'd0, 1'b1, "ill_pulse");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, "ill_clear");
  endtask

  task automatic test_reset_mid();
    opcode = 6'b101011;
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "rm_fetch");
    cyc(1'b0, 1'b1, 4'd1, 1'b0, "rm_decode");
    cyc(1'b0, 1'b1, 4'd2, 1'b0, "rm_addr");
    cyc(1'b0, 1'b0, 4'd5, 1'b0, "rm_wr_wait");
    cyc(1'b1, 1'b0, 4'd5, 1'b0, "rm_wr_reset");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, "rm_after");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
